compare_channel_scheduler: RTL

//  Time-shares one registered magnitude comparator across CHANNELS angle-compare channels.

---
 rtl/compare_channel_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/compare_channel_scheduler.sv
// Round-robin angle-compare scheduler: one registered comparator time-shared across CHANNELS set/reset windows.
// Build option COMPARE_SHADOW_EN: threshold writes land in shadows copied to the live pair when a channel consumes pend.
module compare_channel_scheduler #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 8,
    parameter int CH_W     = 3
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic                ena_i,
    input  logic [WIDTH-1:0]    angle_i,
    input  logic                cycle_start_i,
    input  logic [CHANNELS-1:0] arm_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic                cfg_sel_i,
    input  logic [WIDTH-1:0]    cfg_data_i,
    output logic [CHANNELS-1:0] out_o,
    output logic [CHANNELS-1:0] cfg_err_o,
    output logic [CH_W-1:0]     scan_ch_o
);
    typedef enum logic [1:0] {IDLE, WAIT_SET, ACTIVE, DONE} state_e;
    localparam int STAGES = 1;

    logic [CH_W-1:0]                scan_q, s0_ch_q, s1_ch_q;
    logic [STAGES:0]                vld_pipe_q;
    logic [WIDTH-1:0]               s0_angle_q, s0_set_q, s0_rst_q;
    logic                           ge_set_q, ge_rst_q, valid_q;
    logic [CHANNELS-1:0][WIDTH-1:0] set_q, rst_q;
    logic [CHANNELS-1:0]            pend_q, out_q, err_q;
    state_e                         st_q [CHANNELS];
    state_e                         cur_st, st_d;
    logic                           s2_go, ch_arm, ch_pend, consume, wr_ok;

    assign s2_go = ena_i & vld_pipe_q[STAGES];
    assign wr_ok = cfg_we_i && (int'(cfg_ch_i) < CHANNELS);

    // Scanner plus S0/S1 stages
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            scan_q     <= '0;
            vld_pipe_q <= '0;
            s0_ch_q    <= '0;
            s0_angle_q <= '0;
            s0_set_q   <= '0;
            s0_rst_q   <= '0;
            s1_ch_q    <= '0;
            ge_set_q   <= 1'b0;
            ge_rst_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else if (ena_i) begin
            scan_q     <= (scan_q == CH_W'(CHANNELS - 1)) ? '0 : scan_q + 1'b1;
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], 1'b1};
            s0_ch_q    <= scan_q;
            s0_angle_q <= angle_i;
            s0_set_q   <= set_q[scan_q];
            s0_rst_q   <= rst_q[scan_q];
            s1_ch_q    <= s0_ch_q;
            ge_set_q   <= s0_angle_q >= s0_set_q;
            ge_rst_q   <= s0_angle_q >= s0_rst_q;
            valid_q    <= s0_set_q < s0_rst_q;
        end
    end

    // S2 next-state for the channel currently leaving S1
    always_comb begin
        cur_st  = st_q[s1_ch_q];
        ch_arm  = arm_i[s1_ch_q];
        ch_pend = pend_q[s1_ch_q];
        st_d    = cur_st;
        consume = 1'b0;
        case (cur_st)
            IDLE: begin
                consume = 1'b1;
                if (ch_arm) st_d = WAIT_SET;
            end
            WAIT_SET: begin
                consume = 1'b1;
                if (!ch_arm)                                st_d = IDLE;
                else if (ge_set_q && !ge_rst_q && valid_q)  st_d = ACTIVE;
                else if (ge_rst_q && valid_q)               st_d = DONE;
            end
            ACTIVE: begin
                if (!ch_arm || ge_rst_q) st_d = DONE;
            end
            DONE: begin
                consume = 1'b1;
                if (ch_pend) st_d = ch_arm ? WAIT_SET : IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < CHANNELS; i++) st_q[i] <= IDLE;
            out_q <= '0;
        end else if (s2_go) begin
            st_q[s1_ch_q]  <= st_d;
            out_q[s1_ch_q] <= (st_d == ACTIVE);
        end
    end

    // A fresh cycle_start beats a same-edge consume
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pend_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cycle_start_i)
                    pend_q[i] <= 1'b1;
                else if (s2_go && consume && (s1_ch_q == CH_W'(i)))
                    pend_q[i] <= 1'b0;
            end
        end
    end

`ifdef COMPARE_SHADOW_EN
    logic [CHANNELS-1:0][WIDTH-1:0] sh_set_q, sh_rst_q;
    logic                           copy;

    assign copy = ch_pend & (consume | (cur_st == ACTIVE && st_d == DONE));

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sh_set_q <= '0;
            sh_rst_q <= '0;
            set_q    <= '0;
            rst_q    <= '0;
        end else begin
            if (wr_ok) begin
                if (cfg_sel_i) sh_rst_q[cfg_ch_i] <= cfg_data_i;
                else           sh_set_q[cfg_ch_i] <= cfg_data_i;
            end
            if (s2_go && copy) begin
                set_q[s1_ch_q] <= sh_set_q[s1_ch_q];
                rst_q[s1_ch_q] <= sh_rst_q[s1_ch_q];
            end
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            set_q <= '0;
            rst_q <= '0;
        end else if (wr_ok) begin
            if (cfg_sel_i) rst_q[cfg_ch_i] <= cfg_data_i;
            else           set_q[cfg_ch_i] <= cfg_data_i;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            err_q <= '0;
        end else if (ena_i) begin
            for (int i = 0; i < CHANNELS; i++) err_q[i] <= !(set_q[i] < rst_q[i]);
        end
    end

    assign out_o     = out_q;
    assign cfg_err_o = err_q;
    assign scan_ch_o = scan_q;
endmodule
